// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared region map, error data and bridge state encoding
package cpu_bus_pkg;

    localparam logic [31:0] SDRAM_MASK = 32'hFC00_0000;
    localparam logic [31:0] DMEM_MASK  = 32'hFFFF_0000;
    localparam logic [31:0] DMEM_BASE  = 32'h8000_0000;
    localparam logic [31:0] IO_MASK    = 32'hFFFF_F000;
    localparam logic [31:0] IO_BASE    = 32'hE000_0000;
    localparam logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        IDLE,
        DM_RD,
        IO_RD,
        SD_REQ,
        SD_WAIT,
        ERR
    } bus_state_t;

endpackage

// File: rtl/cpu_dbus_decode.sv
// rtl/cpu_dbus_decode.sv - one-hot address-to-target decode shared with the icache
module cpu_dbus_decode
    import cpu_bus_pkg::*;
(
    input  logic [31:0] address,
    output logic        hit_sdram,
    output logic        hit_dmem,
    output logic        hit_io,
    output logic        hit_err
);

    always_comb begin
        hit_sdram = (address & SDRAM_MASK) == 32'h0;
        hit_dmem  = (address & DMEM_MASK) == DMEM_BASE;
        hit_io    = (address & IO_MASK) == IO_BASE;
        hit_err   = !(hit_sdram || hit_dmem || hit_io);
    end

endmodule

// File: rtl/cpu_dbus_bridge.sv
// rtl/cpu_dbus_bridge.sv - cpu data port bridge to data RAM, SDRAM arbiter and IO bus
module cpu_dbus_bridge #(
    parameter int          DMEM_AW        = 14,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = cpu_bus_pkg::ERR_RDATA
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cpu_request,
    input  logic [31:0]        cpu_address,
    input  logic               cpu_write,
    input  logic [3:0]         cpu_wstrb,
    input  logic [31:0]        cpu_wdata,
    output logic [31:0]        cpu_rdata,
    output logic               cpu_mem_busy,
    output logic               cpu_valid,
    output logic               cpu_error,
    output logic               dmem_en,
    output logic [3:0]         dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    input  logic [31:0]        dmem_rdata,
    output logic               sdram_request,
    output logic [25:0]        sdram_address,
    output logic               sdram_write,
    output logic [3:0]         sdram_wstrb,
    output logic [31:0]        sdram_wdata,
    input  logic               sdram_ack,
    input  logic [31:0]        sdram_rdata,
    input  logic               sdram_valid,
    output logic               io_en,
    output logic               io_write,
    output logic [9:0]         io_addr,
    output logic [3:0]         io_wstrb,
    output logic [31:0]        io_wdata,
    input  logic [31:0]        io_rdata
);
    import cpu_bus_pkg::*;

    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    bus_state_t    state, state_n;
    logic [CW-1:0] tmo_cnt;
    logic          req_write;
    logic          hit_sdram, hit_dmem, hit_io, hit_err;
    logic          accept, timed_out;

    cpu_dbus_decode u_decode (
        .address   (cpu_address),
        .hit_sdram (hit_sdram),
        .hit_dmem  (hit_dmem),
        .hit_io    (hit_io),
        .hit_err   (hit_err)
    );

    // Strobes are combinational from the request, so gate them with reset to keep outputs low.
    assign accept       = reset && (state == IDLE) && cpu_request;
    assign timed_out    = tmo_cnt == TMO_LAST;
    assign cpu_mem_busy = state != IDLE;

    always_comb begin
        state_n    = state;
        dmem_en    = 1'b0;
        dmem_we    = 4'h0;
        dmem_addr  = '0;
        dmem_wdata = 32'h0;
        io_en      = 1'b0;
        io_write   = 1'b0;
        io_addr    = 10'h0;
        io_wstrb   = 4'h0;
        io_wdata   = 32'h0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (hit_dmem) begin
                        dmem_en    = 1'b1;
                        dmem_addr  = cpu_address[DMEM_AW+1:2];
                        dmem_wdata = cpu_wdata;
                        if (cpu_write) dmem_we = cpu_wstrb;
                        else           state_n = DM_RD;
                    end else if (hit_io) begin
                        io_en    = 1'b1;
                        io_write = cpu_write;
                        io_addr  = cpu_address[11:2];
                        io_wstrb = cpu_wstrb;
                        io_wdata = cpu_wdata;
                        if (!cpu_write) state_n = IO_RD;
                    end else if (hit_sdram) begin
                        state_n = SD_REQ;
                    end else if (hit_err) begin
                        state_n = ERR;
                    end
                end
            end
            DM_RD, IO_RD, ERR: state_n = IDLE;
            SD_REQ: begin
                // A response in the timeout cycle still wins over the abort.
                if (sdram_ack)      state_n = (sdram_write || sdram_valid) ? IDLE : SD_WAIT;
                else if (timed_out) state_n = ERR;
            end
            SD_WAIT: begin
                if (sdram_valid)    state_n = IDLE;
                else if (timed_out) state_n = ERR;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            req_write     <= 1'b0;
            cpu_rdata     <= 32'h0;
            cpu_valid     <= 1'b0;
            cpu_error     <= 1'b0;
            sdram_request <= 1'b0;
            sdram_address <= 26'h0;
            sdram_write   <= 1'b0;
            sdram_wstrb   <= 4'h0;
            sdram_wdata   <= 32'h0;
        end else begin
            state     <= state_n;
            cpu_valid <= 1'b0;
            cpu_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_write <= cpu_write;
                        if (hit_sdram) begin
                            sdram_request <= 1'b1;
                            sdram_address <= cpu_address[25:0];
                            sdram_write   <= cpu_write;
                            sdram_wstrb   <= cpu_wstrb;
                            sdram_wdata   <= cpu_wdata;
                            tmo_cnt       <= '0;
                        end
                    end
                end
                DM_RD: begin
                    cpu_valid <= 1'b1;
                    cpu_rdata <= dmem_rdata;
                end
                IO_RD: begin
                    cpu_valid <= 1'b1;
                    cpu_rdata <= io_rdata;
                end
                SD_REQ: begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                    if (sdram_ack) begin
                        sdram_request <= 1'b0;
                        if (!sdram_write && sdram_valid) begin
                            cpu_valid <= 1'b1;
                            cpu_rdata <= sdram_rdata;
                        end
                    end else if (timed_out) begin
                        sdram_request <= 1'b0;
                    end
                end
                SD_WAIT: begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                    if (sdram_valid) begin
                        cpu_valid <= 1'b1;
                        cpu_rdata <= sdram_rdata;
                    end
                end
                ERR: begin
                    cpu_error <= 1'b1;
                    if (!req_write) begin
                        cpu_valid <= 1'b1;
                        cpu_rdata <= ERR_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_dbus_bridge.sv
// tb/tb_cpu_dbus_bridge.sv - randomized self-checking bench for cpu_dbus_bridge
module tb_cpu_dbus_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_request = 1'b0;
    logic [31:0] cpu_address = 32'h0;
    logic        cpu_write = 1'b0;
    logic [3:0]  cpu_wstrb = 4'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic [31:0] cpu_rdata;
    logic        cpu_mem_busy, cpu_valid, cpu_error;
    logic        dmem_en;
    logic [3:0]  dmem_we;
    logic [13:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = 32'h0;
    logic        sdram_request;
    logic [25:0] sdram_address;
    logic        sdram_write;
    logic [3:0]  sdram_wstrb;
    logic [31:0] sdram_wdata;
    logic        sdram_ack = 1'b0;
    logic [31:0] sdram_rdata = 32'h0;
    logic        sdram_valid = 1'b0;
    logic        io_en, io_write;
    logic [9:0]  io_addr;
    logic [3:0]  io_wstrb;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata = 32'h0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] env_dm [0:16383];
    logic [31:0] env_io [0:1023];
    logic [31:0] env_sd [0:4095];
    logic [31:0] ref_m [logic [31:0]];

    always #5 clock = ~clock;

    cpu_dbus_bridge dut (
        .clock (clock), .reset (reset),
        .cpu_request (cpu_request), .cpu_address (cpu_address), .cpu_write (cpu_write),
        .cpu_wstrb (cpu_wstrb), .cpu_wdata (cpu_wdata), .cpu_rdata (cpu_rdata),
        .cpu_mem_busy (cpu_mem_busy), .cpu_valid (cpu_valid), .cpu_error (cpu_error),
        .dmem_en (dmem_en), .dmem_we (dmem_we), .dmem_addr (dmem_addr),
        .dmem_wdata (dmem_wdata), .dmem_rdata (dmem_rdata),
        .sdram_request (sdram_request), .sdram_address (sdram_address),
        .sdram_write (sdram_write), .sdram_wstrb (sdram_wstrb), .sdram_wdata (sdram_wdata),
        .sdram_ack (sdram_ack), .sdram_rdata (sdram_rdata), .sdram_valid (sdram_valid),
        .io_en (io_en), .io_write (io_write), .io_addr (io_addr),
        .io_wstrb (io_wstrb), .io_wdata (io_wdata), .io_rdata (io_rdata)
    );

    // Target memories: RAM and IO have one cycle of read latency, SDRAM writes land on ack.
    initial begin
        for (int i = 0; i < 16384; i++) env_dm[i] = 32'h0;
        for (int i = 0; i < 1024; i++)  env_io[i] = 32'h0;
        for (int i = 0; i < 4096; i++)  env_sd[i] = 32'h0;
        forever begin
            @(posedge clock);
            if (dmem_en) begin
                dmem_rdata <= env_dm[dmem_addr];
                for (int b = 0; b < 4; b++)
                    if (dmem_we[b]) env_dm[dmem_addr][8*b +: 8] <= dmem_wdata[8*b +: 8];
            end
            if (io_en) begin
                io_rdata <= env_io[io_addr];
                for (int b = 0; b < 4; b++)
                    if (io_write && io_wstrb[b]) env_io[io_addr][8*b +: 8] <= io_wdata[8*b +: 8];
            end
            if (sdram_request && sdram_ack && sdram_write)
                for (int b = 0; b < 4; b++)
                    if (sdram_wstrb[b]) env_sd[sdram_address[13:2]][8*b +: 8] <= sdram_wdata[8*b +: 8];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // 0 = SDRAM, 1 = data RAM, 2 = IO, 3 = decode error
    function automatic int region_of(input logic [31:0] a);
        if (a < 32'h0400_0000) return 0;
        if (a[31:16] == 16'h8000) return 1;
        if (a[31:12] == 20'hE0000) return 2;
        return 3;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        logic [31:0] key;
        key = a & ~32'h3;
        return ref_m.exists(key) ? ref_m[key] : 32'h0;
    endfunction

    task automatic ref_wr(input logic [31:0] a, input logic [3:0] st, input logic [31:0] wd);
        logic [31:0] v;
        v = ref_rd(a);
        for (int b = 0; b < 4; b++)
            if (st[b]) v[8*b +: 8] = wd[8*b +: 8];
        ref_m[a & ~32'h3] = v;
    endtask

    // Called and returns at a falling edge; ack_d = request cycles until ack (0 = never),
    // val_d = cycles from ack to read data (0 = same cycle, large = never).
    task automatic do_txn(input logic wr, input logic [31:0] a, input logic [3:0] st,
                          input logic [31:0] wd, input int ack_d, input int val_d);
        int rg, c_done, k_end, reqc, stray, k;
        bit tmo, exp_v, exp_e, got_v, got_e;
        logic [31:0] exp_d, got_d;
        rg = region_of(a);
        tmo = 1'b0;
        if (rg == 0) begin
            c_done = wr ? ack_d : ack_d + val_d;
            tmo    = (ack_d == 0) || (c_done > 255);
            k_end  = tmo ? 257 : c_done + 1;
        end else begin
            k_end = (wr && rg != 3) ? 1 : 2;
        end
        exp_e = (rg == 3) || tmo;
        exp_v = !wr;
        exp_d = exp_e ? 32'hDEADBEEF : ref_rd(a);

        cpu_request = 1'b1; cpu_write = wr; cpu_address = a; cpu_wstrb = st; cpu_wdata = wd;
        sdram_ack = 1'b0; sdram_valid = 1'b0;
        #1;
        check_eq("busy_c0", cpu_mem_busy, 0);
        check_eq("dmem_en", dmem_en, rg == 1);
        check_eq("dmem_we", dmem_we, (rg == 1 && wr) ? st : 4'h0);
        check_eq("io_en", io_en, rg == 2);
        check_eq("io_write", io_write, rg == 2 && wr);
        check_eq("sd_req_c0", sdram_request, 0);
        if (rg == 1) check_eq("dmem_addr", dmem_addr, a[15:2]);
        if (rg == 2) check_eq("io_addr", io_addr, a[11:2]);

        reqc = 0; stray = 0; got_v = 0; got_e = 0; got_d = 32'h0;
        for (k = 1; k <= 300; k++) begin
            @(negedge clock);
            cpu_request = 1'b0; sdram_ack = 1'b0; sdram_valid = 1'b0;
            if (sdram_request) reqc++;
            if (!cpu_mem_busy) begin
                got_v = cpu_valid; got_e = cpu_error; got_d = cpu_rdata;
                break;
            end
            if (cpu_valid || cpu_error) stray++;
            if (rg == 0 && ack_d != 0 && k == ack_d) begin
                sdram_ack = 1'b1;
                check_eq("sd_addr", sdram_address, a[25:0]);
                check_eq("sd_write", sdram_write, wr);
                check_eq("sd_wstrb", sdram_wstrb, st);
                if (wr) check_eq("sd_wdata", sdram_wdata, wd);
            end
            if (rg == 0 && !wr && ack_d != 0 && k == ack_d + val_d) begin
                sdram_valid = 1'b1;
                sdram_rdata = env_sd[sdram_address[13:2]];
            end
        end
        check_eq("latency", k, k_end);
        check_eq("valid", got_v, exp_v);
        check_eq("error", got_e, exp_e);
        check_eq("stray_pulse", stray, 0);
        if (exp_v) check_eq("rdata", got_d, exp_d);
        if (rg == 0) check_eq("sd_req_cycles", reqc, (ack_d == 0) ? 255 : ack_d);
        if (wr && !exp_e) ref_wr(a, st, wd);
    endtask

    // Reset during SD_REQ (ack_d = 0) or SD_WAIT (ack_d > 0), then a late sdram_valid.
    task automatic reset_mid(input int ack_d);
        cpu_request = 1'b1; cpu_write = 1'b0; cpu_address = 32'h0000_0200; cpu_wstrb = 4'hF;
        for (int k = 1; k <= ack_d + 2; k++) begin
            @(negedge clock);
            cpu_request = 1'b0;
            sdram_ack = (k == ack_d);
        end
        check_eq("rst_pre_busy", cpu_mem_busy, 1);
        check_eq("rst_pre_req", sdram_request, ack_d == 0);
        reset = 1'b0;
        #1;
        check_eq("rst_busy", cpu_mem_busy, 0);
        check_eq("rst_req", sdram_request, 0);
        check_eq("rst_valid", cpu_valid, 0);
        check_eq("rst_error", cpu_error, 0);
        check_eq("rst_rdata", cpu_rdata, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        sdram_valid = 1'b1; sdram_rdata = 32'h1111_2222;
        repeat (3) begin
            @(negedge clock);
            sdram_valid = 1'b0;
            check_eq("late_valid", cpu_valid, 0);
            check_eq("late_busy", cpu_mem_busy, 0);
        end
    endtask

    initial begin
        logic [31:0] err_tab [6];
        logic [31:0] a;
        int r, ack_d;
        err_tab = '{32'h0400_0000, 32'h7FFF_FFFC, 32'h8001_0000,
                    32'hDFFF_FFFC, 32'hE000_1000, 32'hFFFF_FFFC};
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_eq("init_busy", cpu_mem_busy, 0);
        check_eq("init_valid", cpu_valid, 0);
        check_eq("init_error", cpu_error, 0);
        check_eq("init_rdata", cpu_rdata, 0);
        check_eq("init_sd_req", sdram_request, 0);
        check_eq("init_dmem_en", dmem_en, 0);
        check_eq("init_io_en", io_en, 0);
        reset = 1'b1;
        @(negedge clock);

        do_txn(1, 32'h8000_0010, 4'hF, 32'h1234_5678, 0, 0);
        do_txn(0, 32'h8000_0010, 4'hF, 32'h0, 0, 0);
        do_txn(1, 32'h8000_0010, 4'b0101, 32'hAABB_CCDD, 0, 0);
        do_txn(1, 32'h8000_0010, 4'h0, 32'hFFFF_FFFF, 0, 0);
        do_txn(0, 32'h8000_0010, 4'hF, 32'h0, 0, 0);
        do_txn(1, 32'h8000_FFFC, 4'hF, 32'h0BAD_F00D, 0, 0);
        do_txn(0, 32'h8000_FFFC, 4'hF, 32'h0, 0, 0);
        do_txn(1, 32'hE000_0004, 4'hF, 32'hA5A5_A5A5, 0, 0);
        do_txn(0, 32'hE000_0004, 4'hF, 32'h0, 0, 0);
        do_txn(1, 32'hE000_0FFC, 4'b1100, 32'h5566_7788, 0, 0);
        do_txn(0, 32'hE000_0FFC, 4'hF, 32'h0, 0, 0);
        do_txn(1, 32'h0000_0100, 4'hF, 32'hCAFE_F00D, 2, 0);
        do_txn(0, 32'h0000_0100, 4'hF, 32'h0, 3, 5);
        do_txn(0, 32'h0000_0100, 4'hF, 32'h0, 1, 0);
        do_txn(1, 32'h03FF_FFFC, 4'hF, 32'h7777_8888, 1, 0);
        do_txn(0, 32'h03FF_FFFC, 4'hF, 32'h0, 2, 1);
        do_txn(0, 32'h4000_0000, 4'hF, 32'h0, 0, 0);
        do_txn(1, 32'h4000_0000, 4'hF, 32'h1, 0, 0);
        do_txn(0, 32'h0000_0100, 4'hF, 32'h0, 0, 0);
        do_txn(0, 32'h8000_0010, 4'hF, 32'h0, 0, 0);
        do_txn(1, 32'h0000_0104, 4'hF, 32'h1357_9BDF, 0, 0);
        do_txn(1, 32'h0000_0108, 4'hF, 32'h2468_ACE0, 255, 0);
        do_txn(0, 32'h0000_0108, 4'hF, 32'h0, 100, 155);
        do_txn(0, 32'h0000_0108, 4'hF, 32'h0, 100, 156);
        do_txn(0, 32'h0000_0104, 4'hF, 32'h0, 1, 0);
        foreach (err_tab[i]) do_txn(0, err_tab[i], 4'hF, 32'h0, 0, 0);

        reset_mid(0);
        do_txn(0, 32'h0000_0100, 4'hF, 32'h0, 1, 2);
        reset_mid(3);
        do_txn(0, 32'hE000_0004, 4'hF, 32'h0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      a = 32'($urandom_range(0, 255)) * 4;
            else if (r < 6) a = 32'h8000_0000 + 32'($urandom_range(0, 63)) * 4;
            else if (r < 9) a = 32'hE000_0000 + 32'($urandom_range(0, 31)) * 4;
            else            a = err_tab[$urandom_range(0, 5)];
            ack_d = ($urandom_range(0, 24) == 0) ? 0 : int'($urandom_range(1, 6));
            do_txn(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom,
                   ack_d, int'($urandom_range(0, 6)));
        end

        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_dbus_bridge.md
Name: cpu_dbus_bridge

Overview:
- Data-side bus bridge that sits directly downstream of the cpu data port (cpu_request/cpu_address/cpu_write/cpu_wstrb/cpu_wdata). It returns cpu_rdata/cpu_mem_busy/cpu_valid to that port.
- Decodes each address and routes the access to one of three targets: on-chip data RAM, the SDRAM arbiter port, or the IO register bus.
- Only one transaction is outstanding at a time. A watchdog aborts SDRAM accesses that hang.

Parameters:
- DMEM_AW, 14, word-address width of the data RAM (64 KB).
- TIMEOUT_CYCLES, 255, cycles without SDRAM ack/valid before the access is aborted.
- ERR_RDATA, 32'hDEADBEEF, read data returned on a decode error or a timeout.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cpu_request  in  1  cpu access request.
- cpu_address  in  32  byte address.
- cpu_write  in  1  1 = write, 0 = read.
- cpu_wstrb  in  4  byte enables.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data, meaningful only while cpu_valid is high.
- cpu_mem_busy  out  1  bridge cannot accept a new request.
- cpu_valid  out  1  one-cycle pulse: read data is ready.
- cpu_error  out  1  one-cycle pulse: decode error or timeout.
- dmem_en  out  1  RAM enable.
- dmem_we  out  4  RAM byte write enables.
- dmem_addr  out  DMEM_AW  RAM word address.
- dmem_wdata  out  32  RAM write data.
- dmem_rdata  in  32  RAM read data (1-cycle latency).
- sdram_request  out  1  request to the SDRAM arbiter.
- sdram_address  out  26  SDRAM byte address.
- sdram_write  out  1  SDRAM write.
- sdram_wstrb  out  4  SDRAM byte enables.
- sdram_wdata  out  32  SDRAM write data.
- sdram_ack  in  1  SDRAM arbiter accepted the request.
- sdram_rdata  in  32  SDRAM read data.
- sdram_valid  in  1  SDRAM read data is valid.
- io_en  out  1  IO access strobe.
- io_write  out  1  IO write.
- io_addr  out  10  IO word address.
- io_wstrb  out  4  IO byte enables.
- io_wdata  out  32  IO write data.
- io_rdata  in  32  IO read data (1-cycle latency).

Behaviour:
- Address decode:
  - SDRAM: cpu_address[31:26] == 0.
  - DMEM: cpu_address[31:16] == 16'h8000.
  - IO: cpu_address[31:12] == 20'hE0000.
  - Any other address is a decode error.
- Reset (reset low, asynchronous):
  - state = IDLE.
  - All outputs 0, except cpu_rdata = 0.
  - Timeout counter = 0.
  - Reset mid-transaction drops sdram_request immediately. A late sdram_valid after reset is ignored.
- A request is accepted only when the state is IDLE and cpu_request is high. cpu_mem_busy = (state != IDLE). The cpu holds a request while busy is high.
- States:
  - IDLE:
    - DMEM write: dmem_en=1 and dmem_we=cpu_wstrb in the same cycle. Stay in IDLE; no valid pulse.
    - DMEM read: dmem_en=1, go to DM_RD.
    - IO write: io_en=1, io_write=1 in the same cycle. Stay in IDLE.
    - IO read: io_en=1, go to IO_RD.
    - SDRAM access: register address, write, wstrb and wdata; assert sdram_request; go to SD_REQ.
    - Decode error: go to ERR.
  - DM_RD: cpu_rdata = dmem_rdata, cpu_valid = 1 for one cycle, go to IDLE. Load-use latency is 2 cycles from request.
  - IO_RD: same as DM_RD, using io_rdata.
  - SD_REQ:
    - sdram_request stays high until sdram_ack. It deasserts in the cycle after the ack.
    - On ack with a write: go to IDLE; no valid pulse.
    - On ack with a read: go to SD_WAIT.
  - SD_WAIT: on sdram_valid, register sdram_rdata, pulse cpu_valid, go to IDLE.
  - ERR: pulse cpu_error. For reads, also pulse cpu_valid with cpu_rdata = ERR_RDATA. Go to IDLE.
- Timeout counter:
  - Clears on entry to SD_REQ and increments every cycle spent in SD_REQ or SD_WAIT.
  - When the count reaches TIMEOUT_CYCLES, drop sdram_request and go to ERR.
  - sdram_valid or sdram_ack arriving in the same cycle as the timeout takes priority over the timeout.
- Simultaneous events:
  - sdram_ack and sdram_valid together in SD_REQ (read): complete the read directly and return to IDLE.
  - Unsolicited sdram_valid in IDLE is ignored.
- cpu_wstrb == 0 writes are forwarded unchanged; no special case.
- A back-to-back request in the cycle the state returns to IDLE is accepted; there is no dead cycle.

Decomposition:
- Shared package cpu_bus_pkg holds:
  - the region base/mask constants (SDRAM_MASK, DMEM_BASE, IO_BASE);
  - the FSM state encoding enum (IDLE, DM_RD, IO_RD, SD_REQ, SD_WAIT, ERR);
  - ERR_RDATA.
- One sub-module: cpu_dbus_decode, a combinational address-to-target one-hot decode that is reused by the icache.

Test Plan:
- DMEM write 0x80000010 wdata 0x12345678 wstrb 4'b1111, then a read of the same address -> dmem_we=4'hF in cycle 0; the read gives cpu_valid 2 cycles after the request with rdata 0x12345678; busy high for 1 cycle.
- IO read 0xE0000004 with io_rdata=0xA5A5A5A5 -> io_addr=1, cpu_valid one cycle later with 0xA5A5A5A5.
- SDRAM read 0x00000100, ack after 3 cycles, valid 5 cycles later with 0xCAFEF00D -> sdram_request high exactly 3 cycles; busy throughout; cpu_valid single pulse with 0xCAFEF00D.
- Read of 0x40000000 -> cpu_error and cpu_valid pulse together with rdata 0xDEADBEEF; no target strobe.
- SDRAM read with no ack -> after 255 cycles sdram_request drops; cpu_error + cpu_valid pulse with 0xDEADBEEF; the next request is accepted.
- reset asserted during SD_WAIT, then a late sdram_valid -> outputs 0 immediately; no cpu_valid pulse after reset is released.
